// File: rtl/shift_xfer_sched_pkg.sv
// Shared types and constants for the load/shift register transfer sequencer.
package shift_xfer_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } xfer_state_e;

  localparam int REQ0 = 0;
  localparam int REQ1 = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin pick. rr_ptr holds the index of the previous owner;
// on contention the other requester wins.
module rr_arb2
  import shift_xfer_sched_pkg::*;
(
  input  logic [1:0] req,
  input  logic       rr_ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (rr_ptr == 1'(REQ0)) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/shift_xfer_sched.sv
// Arbitrates two requesters onto one load/shift register: one load cycle,
// WIDTH shift cycles, then a done pulse (or an abort acknowledge) to the owner.
module shift_xfer_sched
  import shift_xfer_sched_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [1:0]       req_i2,
  input  logic [WIDTH-1:0] data0_i4,
  input  logic [WIDTH-1:0] data1_i4,
  input  logic [1:0]       fill_i2,
  input  logic [1:0]       abort_i2,
  output logic             ld_o,
  output logic             shift_o,
  output logic [WIDTH-1:0] I_o4,
  output logic             bstream_o,
  output logic [1:0]       gnt_o2,
  output logic             busy_o,
  output logic [1:0]       done_o2,
  output logic [1:0]       abrt_o2,
  output logic [1:0]       state_o
);

  // Handshake: req_i2 is a level held by a requester until it sees its bit
  // of done_o2 or abrt_o2; both of those are single-cycle pulses.
  xfer_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] word_q;
  logic [1:0]       gnt_q;
  logic [1:0]       abrt_q;
  logic             rr_q;
  logic [1:0]       arb_gnt;
  logic             owner;
  logic             abort_hit;
  logic             last_shift;

  rr_arb2 u_arb (
    .req    (req_i2),
    .rr_ptr (rr_q),
    .gnt    (arb_gnt)
  );

  assign owner      = gnt_q[REQ1];
  assign abort_hit  = |(abort_i2 & gnt_q) && (state_q == LOAD || state_q == SHIFT);
  assign last_shift = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (|req_i2) state_d = LOAD;
      LOAD:  state_d = abort_hit ? IDLE : SHIFT;
      SHIFT: begin
        if (abort_hit)       state_d = IDLE;
        else if (last_shift) state_d = DONE;
      end
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant, snapshot, shift count and round-robin pointer.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q  <= '0;
      word_q <= '0;
      gnt_q  <= 2'b00;
      abrt_q <= 2'b00;
      rr_q   <= 1'b1;
    end else begin
      abrt_q <= 2'b00;
      case (state_q)
        IDLE: begin
          if (|req_i2) begin
            gnt_q  <= arb_gnt;
            word_q <= arb_gnt[REQ1] ? data1_i4 : data0_i4;
          end
        end
        LOAD, SHIFT: begin
          cnt_q <= (state_q == LOAD) ? '0 : cnt_q + 1'b1;
          if (abort_hit) begin
            gnt_q  <= 2'b00;
            abrt_q <= gnt_q;
            rr_q   <= owner;
          end
        end
        DONE: begin
          gnt_q <= 2'b00;
          rr_q  <= owner;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ld_o      = 1'b0;
    shift_o   = 1'b0;
    I_o4      = '0;
    bstream_o = 1'b0;
    done_o2   = 2'b00;
    gnt_o2    = gnt_q;
    busy_o    = (state_q != IDLE);
    abrt_o2   = abrt_q;
    state_o   = state_q;
    case (state_q)
      LOAD: begin
        ld_o = 1'b1;
        I_o4 = word_q;
      end
      SHIFT: begin
        shift_o   = 1'b1;
        bstream_o = fill_i2[owner];
      end
      DONE:    done_o2 = gnt_q;
      default: ;
    endcase
  end

endmodule
